// File: rtl/md_pkg.sv
// Shared encodings and helpers for the parameterised multiply/divide unit.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b100;
    localparam logic [2:0] MD_MULTU = 3'b101;
    localparam logic [2:0] MD_DIV   = 3'b110;
    localparam logic [2:0] MD_DIVU  = 3'b111;

    // Widest 2*WIDTH value the helper must handle.
    localparam int MD_MAXW = 128;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;

    // Two's-complement magnitude / conditional negate. Callers zero-extend in
    // and cast back, so -2^(W-1) yields the correct unsigned magnitude.
    function automatic logic [MD_MAXW-1:0] md_mag(input logic [MD_MAXW-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/md_mul_step.sv
// Combinational shift-add retiring MUL_STEP multiplier bits from the low half of the accumulator.
module md_mul_step #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH:0]     w_hi;

    // The carry out of each add lands in bit WIDTH and is shifted into the upper half.
    always_comb begin
        w_acc = i_acc;
        w_hi  = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            w_hi  = {1'b0, w_acc[2*WIDTH-1:WIDTH]} + (w_acc[0] ? {1'b0, i_mcand} : '0);
            w_acc = {w_hi, w_acc[WIDTH-1:1]};
        end
    end

    assign o_acc = w_acc;

endmodule

// File: rtl/md_unit_param.sv
// Iterative multiply/divide unit with hold, kill, MTHI/MTLO and a sticky divide-by-zero flag.
module md_unit_param
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1,
    parameter int CNT_W    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             MRST,
    input  logic [2:0]       iMDtype,
    input  logic [WIDTH-1:0] iRS,
    input  logic [WIDTH-1:0] iRT,
    input  logic             iHold,
    input  logic             iKill,
    input  logic             iWrHI,
    input  logic             iWrLO,
    input  logic [WIDTH-1:0] iWrData,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO,
    output logic             oReady,
    output logic             oDivZero
);

    localparam int W2 = 2 * WIDTH;

    md_state_e        r_state, w_nstate;
    logic [CNT_W-1:0] r_cnt;
    logic [W2-1:0]    r_acc, w_mul_acc, w_div_acc, w_prod;
    logic [WIDTH-1:0] r_m, r_a, r_hi, r_lo;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_quo, w_rem, w_fix_hi, w_fix_lo;
    logic [WIDTH:0]   w_shl, w_sub;
    logic             r_sa, r_sb, r_div, r_dz;
    logic             w_start, w_step, w_commit, w_wr_ok, w_sgn, w_zero;

    md_mul_step #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
        .i_acc   (r_acc),
        .i_mcand (r_m),
        .o_acc   (w_mul_acc)
    );

    always_comb begin
        w_nstate = r_state;
        w_start  = 1'b0;
        w_commit = 1'b0;
        if (iKill) begin
            w_nstate = IDLE;
        end else if (!iHold) begin
            case (r_state)
                IDLE: if (iMDtype[2]) begin
                    w_start  = 1'b1;
                    w_nstate = iMDtype[1] ? DIV : MUL;
                end
                MUL, DIV: if (r_cnt == CNT_W'(1)) w_nstate = FIX;
                FIX: begin
                    w_commit = 1'b1;
                    w_nstate = IDLE;
                end
                default: w_nstate = IDLE;
            endcase
        end
    end

    assign w_step  = !iKill && !iHold && (r_state == MUL || r_state == DIV);
    assign w_wr_ok = (r_state == IDLE) && !iHold;

    assign w_sgn   = ~iMDtype[0];
    assign w_mag_a = WIDTH'(md_mag(MD_MAXW'(iRS), w_sgn & iRS[WIDTH-1]));
    assign w_mag_b = WIDTH'(md_mag(MD_MAXW'(iRT), w_sgn & iRT[WIDTH-1]));

    // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign w_shl     = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
    assign w_sub     = w_shl - {1'b0, r_m};
    assign w_div_acc = w_sub[WIDTH] ? {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_zero   = (r_m == '0);
    assign w_prod   = W2'(md_mag(MD_MAXW'(r_acc), r_sa ^ r_sb));
    assign w_quo    = WIDTH'(md_mag(MD_MAXW'(r_acc[WIDTH-1:0]), r_sa ^ r_sb));
    assign w_rem    = WIDTH'(md_mag(MD_MAXW'(r_acc[W2-1:WIDTH]), r_sa));
    assign w_fix_hi = !r_div ? w_prod[W2-1:WIDTH] : (w_zero ? r_a : w_rem);
    assign w_fix_lo = !r_div ? w_prod[WIDTH-1:0]  : (w_zero ? '1  : w_quo);

    always_ff @(posedge CLK or posedge MRST) begin
        if (MRST) r_state <= IDLE;
        else      r_state <= w_nstate;
    end

    always_ff @(posedge CLK or posedge MRST) begin
        if (MRST) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_m   <= '0;
            r_a   <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_dz  <= 1'b0;
        end else begin
            if (w_wr_ok && iWrHI) r_hi <= iWrData;
            if (w_wr_ok && iWrLO) r_lo <= iWrData;
            if (w_start) begin
                r_a   <= iRS;
                r_sa  <= w_sgn & iRS[WIDTH-1];
                r_sb  <= w_sgn & iRT[WIDTH-1];
                r_div <= iMDtype[1];
                r_dz  <= 1'b0;
                if (iMDtype[1]) begin
                    r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                    r_m   <= w_mag_b;
                    r_cnt <= CNT_W'(WIDTH);
                end else begin
                    r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                    r_m   <= w_mag_a;
                    r_cnt <= CNT_W'(WIDTH / MUL_STEP);
                end
            end
            if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
                r_acc <= (r_state == DIV) ? w_div_acc : w_mul_acc;
            end
            if (w_commit) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
                r_dz <= r_div & w_zero;
            end
        end
    end

    assign oHI      = r_hi;
    assign oLO      = r_lo;
    assign oReady   = (r_state == IDLE);
    assign oDivZero = r_dz;

endmodule

// File: tb/tb_md_unit_param.sv
// Runs three configurations (32/1, 32/4, 16/2) in lockstep against an arithmetic reference model.
module tb_md_unit_param;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ty;
    logic [31:0] rs, rt, wd;
    logic        hold, kill, whi, wlo;

    logic [31:0] hi32, lo32, hi4, lo4;
    logic [15:0] hi16, lo16;
    logic        rdy32, rdy4, rdy16, dz32, dz4, dz16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    md_unit_param #(.WIDTH(32), .MUL_STEP(1)) u_dut32 (
        .CLK(clk), .MRST(rst), .iMDtype(ty), .iRS(rs), .iRT(rt), .iHold(hold), .iKill(kill),
        .iWrHI(whi), .iWrLO(wlo), .iWrData(wd), .oHI(hi32), .oLO(lo32), .oReady(rdy32), .oDivZero(dz32));

    md_unit_param #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
        .CLK(clk), .MRST(rst), .iMDtype(ty), .iRS(rs), .iRT(rt), .iHold(hold), .iKill(kill),
        .iWrHI(whi), .iWrLO(wlo), .iWrData(wd), .oHI(hi4), .oLO(lo4), .oReady(rdy4), .oDivZero(dz4));

    md_unit_param #(.WIDTH(16), .MUL_STEP(2)) u_dut16 (
        .CLK(clk), .MRST(rst), .iMDtype(ty), .iRS(rs[15:0]), .iRT(rt[15:0]), .iHold(hold), .iKill(kill),
        .iWrHI(whi), .iWrLO(wlo), .iWrData(wd[15:0]), .oHI(hi16), .oLO(lo16), .oReady(rdy16), .oDivZero(dz16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {HI, LO} for a w-bit unit, each zero-extended to 32 bits.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [63:0] mask, ua, ub, p, hi, lo;
        longint      as, bs, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        as   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        bs   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        hi   = 64'd0;
        lo   = 64'd0;
        if (!op[1]) begin
            p  = op[0] ? ua * ub : 64'(as * bs);
            hi = (p >> w) & mask;
            lo = p & mask;
        end else if (ub == 64'd0) begin
            hi = ua;
            lo = mask;
        end else begin
            if (op[0]) begin q = longint'(ua / ub); r = longint'(ua % ub); end
            else       begin q = as / bs;           r = as % bs;           end
            hi = 64'(r) & mask;
            lo = 64'(q) & mask;
        end
        return {hi[31:0], lo[31:0]};
    endfunction

    // Issue one op; hold for hl cycles starting at busy cycle hs; try an ignored MTHI mid-op.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hs, input int hl);
        int k, c32, c4, c16;
        logic [63:0] e32, e16;
        logic zx32, zx16;
        @(negedge clk); ty = op; rs = a; rt = b;
        @(negedge clk); ty = MD_NONE;
        k = 0; c32 = 0; c4 = 0; c16 = 0;
        while (!(rdy32 && rdy4 && rdy16) && k < 300) begin
            k++;
            if (!rdy32) c32++;
            if (!rdy4)  c4++;
            if (!rdy16) c16++;
            hold = (hl > 0) && (k >= hs) && (k < hs + hl);
            whi  = (k == 2);
            wd   = 32'hDEADBEEF;
            @(negedge clk);
        end
        hold = 1'b0; whi = 1'b0;
        chk("done", {31'd0, rdy32 && rdy4 && rdy16}, 32'd1);
        e32  = ref_md(op, a, b, 32);
        e16  = ref_md(op, a, b, 16);
        zx32 = op[1] && (b == 32'd0);
        zx16 = op[1] && (b[15:0] == 16'd0);
        chk("lat32", 32'(c32), 32'(33 + hl));
        chk("lat4",  32'(c4),  32'((op[1] ? 33 : 9) + hl));
        chk("lat16", 32'(c16), 32'((op[1] ? 17 : 9) + hl));
        chk("hi32", hi32, e32[63:32]);
        chk("lo32", lo32, e32[31:0]);
        chk("hi4",  hi4,  e32[63:32]);
        chk("lo4",  lo4,  e32[31:0]);
        chk("hi16", {16'd0, hi16}, e16[63:32]);
        chk("lo16", {16'd0, lo16}, e16[31:0]);
        chk("dz32", {31'd0, dz32}, {31'd0, zx32});
        chk("dz4",  {31'd0, dz4},  {31'd0, zx32});
        chk("dz16", {31'd0, dz16}, {31'd0, zx16});
    endtask

    task automatic start_busy(input int cycles);
        @(negedge clk); ty = MD_MULT; rs = 32'h0000_1234; rt = 32'h0000_0055;
        @(negedge clk); ty = MD_NONE;
        repeat (cycles - 1) @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'h0000_8000;
            5:       return 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int r;
        logic [2:0] op;
        rst = 1'b1; ty = MD_NONE; rs = '0; rt = '0; wd = '0;
        hold = 1'b0; kill = 1'b0; whi = 1'b0; wlo = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {29'd0, rdy32, rdy4, rdy16}, 32'd7);
        chk("rst_hi",  hi32 | hi4 | {16'd0, hi16}, 32'd0);
        chk("rst_lo",  lo32 | lo4 | {16'd0, lo16}, 32'd0);
        chk("rst_dz",  {29'd0, dz32, dz4, dz16}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        run_op(MD_DIVU,  32'h0000_0064, 32'h0000_0000, 0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 2, 1);
        run_op(MD_MULT,  32'h0000_0003, 32'h0000_0007, 0, 0);
        run_op(MD_DIVU,  32'h0000_0064, 32'h0000_0007, 3, 5);
        run_op(MD_MULT,  32'h0000_8000, 32'h0000_FFFF, 0, 0);
        run_op(MD_DIV,   32'h0000_8000, 32'h0000_FFFF, 0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1, 2);

        // MTHI/MTLO preload, then kill mid-op must leave both untouched.
        @(negedge clk); whi = 1'b1; wlo = 1'b1; wd = 32'h1111_1111;
        @(negedge clk); whi = 1'b0; wlo = 1'b0;
        chk("wr_hi32", hi32, 32'h1111_1111);
        chk("wr_lo16", {16'd0, lo16}, 32'h0000_1111);
        start_busy(6);
        kill = 1'b1;
        @(negedge clk); kill = 1'b0;
        chk("kill_rdy", {29'd0, rdy32, rdy4, rdy16}, 32'd7);
        chk("kill_hi",  hi32, 32'h1111_1111);
        chk("kill_lo",  lo4,  32'h1111_1111);
        start_busy(4);
        kill = 1'b1; hold = 1'b1;
        @(negedge clk); kill = 1'b0; hold = 1'b0;
        chk("khold_rdy", {29'd0, rdy32, rdy4, rdy16}, 32'd7);
        chk("khold_hi",  {16'd0, hi16}, 32'h0000_1111);
        // Start suppressed by kill in IDLE, then by hold (which also blocks MTHI).
        @(negedge clk); ty = MD_MULT; kill = 1'b1;
        @(negedge clk); ty = MD_NONE; kill = 1'b0;
        chk("kidle_rdy", {29'd0, rdy32, rdy4, rdy16}, 32'd7);
        @(negedge clk); ty = MD_DIV; hold = 1'b1; whi = 1'b1; wd = 32'h5555_5555;
        @(negedge clk); ty = MD_NONE; hold = 1'b0; whi = 1'b0;
        chk("hidle_rdy", {29'd0, rdy32, rdy4, rdy16}, 32'd7);
        chk("hidle_hi",  hi32, 32'h1111_1111);

        // Asynchronous reset mid-operation.
        start_busy(5);
        rst = 1'b1;
        #1;
        chk("mrst_rdy", {29'd0, rdy32, rdy4, rdy16}, 32'd7);
        chk("mrst_hi",  hi32 | hi4 | {16'd0, hi16}, 32'd0);
        chk("mrst_lo",  lo32 | lo4 | {16'd0, lo16}, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 3);
            op = {1'b1, r[1:0]};
            run_op(op, pick(), pick(), $urandom_range(1, 4), $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
